// File: rtl/dca_matrix_mac_mmiox_control.sv
// Register-mapped control front end for the matrix MAC MMIOX core: instruction
// packing/queueing, log queueing, clear handshake, config/status and finish counting.

module dca_matrix_mac_mmiox_control_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstnn,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  // Fullness is judged at the start of the cycle: a same-cycle pop does not make room.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module dca_matrix_mac_mmiox_control #(
  parameter int BW_INST    = 128,
  parameter int BW_LOG     = 32,
  parameter int BW_STATUS  = 32,
  parameter int INST_DEPTH = 4,
  parameter int LOG_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rstnn,
  input  logic                 reg_sel,
  input  logic                 reg_write,
  input  logic [4:0]           reg_addr,
  input  logic [31:0]          reg_wdata,
  output logic [31:0]          reg_rdata,
  output logic                 control_rmx_core_config,
  input  logic [BW_STATUS-1:0] control_rmx_core_status,
  output logic                 control_rmx_clear_request,
  input  logic                 control_rmx_clear_finish,
  output logic                 control_rmx_log_fifo_wready,
  input  logic                 control_rmx_log_fifo_wrequest,
  input  logic [BW_LOG-1:0]    control_rmx_log_fifo_wdata,
  output logic                 control_rmx_inst_fifo_rready,
  output logic [BW_INST-1:0]   control_rmx_inst_fifo_rdata,
  input  logic                 control_rmx_inst_fifo_rrequest,
  input  logic                 control_rmx_operation_finish
);
  localparam int INST_WORDS = BW_INST / 32;
  localparam int WCW        = (INST_WORDS > 1) ? $clog2(INST_WORDS) : 1;
  localparam int IAW        = $clog2(INST_DEPTH);
  localparam int LAW        = $clog2(LOG_DEPTH);
  localparam logic [WCW-1:0] LAST_W = WCW'(INST_WORDS - 1);

  localparam logic [2:0] A_CONFIG = 3'd0, A_STATUS = 3'd1, A_CLEAR = 3'd2, A_INST_DATA = 3'd3,
                         A_INST_LEVEL = 3'd4, A_LOG_DATA = 3'd5, A_LOG_LEVEL = 3'd6,
                         A_FINISH_CNT = 3'd7;

  typedef enum logic {IDLE, REQ} clr_state_t;
  clr_state_t state;

  logic [2:0]                   addr;
  logic                         acc_wr, acc_rd, clear_start, busy;
  logic [WCW-1:0]               wcnt;
  logic                         overflow;
  logic [INST_WORDS-1:0][31:0]  stage, inst_word;
  logic                         inst_wr, inst_last;
  logic [IAW:0]                 inst_count;
  logic                         inst_full, inst_empty;
  logic [BW_LOG-1:0]            log_rdata;
  logic [LAW:0]                 log_count;
  logic                         log_full, log_empty;
  logic [31:0]                  finish_cnt;
  logic                         unused_addr_bits;

  assign unused_addr_bits = ^reg_addr[1:0];
  assign addr        = reg_addr[4:2];
  assign acc_wr      = reg_sel && reg_write;
  assign acc_rd      = reg_sel && !reg_write;
  assign busy        = (state == REQ);
  assign clear_start = !busy && acc_wr && (addr == A_CLEAR) && reg_wdata[0];
  assign inst_wr     = !busy && acc_wr && (addr == A_INST_DATA);
  assign inst_last   = inst_wr && (wcnt == LAST_W);

  // The completing word goes straight into the pushed instruction, not via the staging slot.
  always_comb begin
    inst_word = stage;
    inst_word[INST_WORDS-1] = reg_wdata;
  end

  assign control_rmx_inst_fifo_rready = !inst_empty && !busy;
  assign control_rmx_log_fifo_wready  = !log_full && !busy;

  dca_matrix_mac_mmiox_control_fifo #(.W(BW_INST), .DEPTH(INST_DEPTH)) u_inst_fifo (
    .clk   (clk),
    .rstnn (rstnn),
    .flush (clear_start),
    .push  (inst_last),
    .pop   (control_rmx_inst_fifo_rrequest && control_rmx_inst_fifo_rready),
    .wdata (inst_word),
    .rdata (control_rmx_inst_fifo_rdata),
    .count (inst_count),
    .full  (inst_full),
    .empty (inst_empty)
  );

  dca_matrix_mac_mmiox_control_fifo #(.W(BW_LOG), .DEPTH(LOG_DEPTH)) u_log_fifo (
    .clk   (clk),
    .rstnn (rstnn),
    .flush (clear_start),
    .push  (control_rmx_log_fifo_wrequest && control_rmx_log_fifo_wready),
    .pop   (acc_rd && (addr == A_LOG_DATA)),
    .wdata (control_rmx_log_fifo_wdata),
    .rdata (log_rdata),
    .count (log_count),
    .full  (log_full),
    .empty (log_empty)
  );

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state                     <= IDLE;
      control_rmx_clear_request <= 1'b0;
    end else begin
      case (state)
        IDLE: if (clear_start) begin
          state                     <= REQ;
          control_rmx_clear_request <= 1'b1;
        end
        REQ: if (control_rmx_clear_finish) begin
          state                     <= IDLE;
          control_rmx_clear_request <= 1'b0;
        end
        default: begin
          state                     <= IDLE;
          control_rmx_clear_request <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      wcnt                    <= '0;
      overflow                <= 1'b0;
      stage                   <= '0;
      control_rmx_core_config <= 1'b0;
    end else begin
      if (acc_wr && addr == A_CONFIG) control_rmx_core_config <= reg_wdata[0];
      if (clear_start) begin
        wcnt     <= '0;
        overflow <= 1'b0;
      end else begin
        if (inst_wr) begin
          stage[wcnt] <= reg_wdata;
          wcnt        <= inst_last ? '0 : wcnt + 1'b1;
        end
        if (acc_wr && addr == A_INST_LEVEL) overflow <= 1'b0;
        else if (inst_last && inst_full)    overflow <= 1'b1;
      end
    end
  end

  // A clearing write that coincides with a pulse counts that pulse.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn)                             finish_cnt <= '0;
    else if (acc_wr && addr == A_FINISH_CNT) finish_cnt <= {31'd0, control_rmx_operation_finish};
    else if (control_rmx_operation_finish)   finish_cnt <= finish_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) reg_rdata <= '0;
    else if (acc_rd) begin
      case (addr)
        A_CONFIG:     reg_rdata <= {31'd0, control_rmx_core_config};
        A_STATUS:     reg_rdata <= 32'(control_rmx_core_status);
        A_CLEAR:      reg_rdata <= {31'd0, busy};
        A_INST_LEVEL: reg_rdata <= {inst_full, overflow, 6'd0, 8'(wcnt), 16'(inst_count)};
        A_LOG_DATA:   reg_rdata <= log_empty ? 32'd0 : 32'(log_rdata);
        A_LOG_LEVEL:  reg_rdata <= {log_full, 15'd0, 16'(log_count)};
        A_FINISH_CNT: reg_rdata <= finish_cnt;
        default:      reg_rdata <= 32'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_dca_matrix_mac_mmiox_control.sv
// Directed bench: register reads and instruction heads are scoreboarded in queues.

module tb_dca_matrix_mac_mmiox_control;
  logic         clk = 0;
  logic         rstnn = 0;
  logic         reg_sel = 0, reg_write = 0;
  logic [4:0]   reg_addr = 0;
  logic [31:0]  reg_wdata = 0;
  logic [31:0]  reg_rdata;
  logic         core_config;
  logic [31:0]  core_status = 32'h1234_5678;
  logic         clear_request;
  logic         clear_finish = 0;
  logic         log_wready;
  logic         log_wrequest = 0;
  logic [31:0]  log_wdata = 0;
  logic         inst_rready;
  logic [127:0] inst_rdata;
  logic         inst_rrequest = 0;
  logic         op_finish = 0;

  int checks = 0, failures = 0;
  logic [31:0]  exp_q[$];
  string        tag_q[$];
  logic [127:0] inst_q[$];

  always #5 clk = ~clk;

  dca_matrix_mac_mmiox_control #(.BW_INST(128), .BW_LOG(32), .BW_STATUS(32),
                                 .INST_DEPTH(4), .LOG_DEPTH(2)) dut (
    .clk                            (clk),
    .rstnn                          (rstnn),
    .reg_sel                        (reg_sel),
    .reg_write                      (reg_write),
    .reg_addr                       (reg_addr),
    .reg_wdata                      (reg_wdata),
    .reg_rdata                      (reg_rdata),
    .control_rmx_core_config        (core_config),
    .control_rmx_core_status        (core_status),
    .control_rmx_clear_request      (clear_request),
    .control_rmx_clear_finish       (clear_finish),
    .control_rmx_log_fifo_wready    (log_wready),
    .control_rmx_log_fifo_wrequest  (log_wrequest),
    .control_rmx_log_fifo_wdata     (log_wdata),
    .control_rmx_inst_fifo_rready   (inst_rready),
    .control_rmx_inst_fifo_rdata    (inst_rdata),
    .control_rmx_inst_fifo_rrequest (inst_rrequest),
    .control_rmx_operation_finish   (op_finish)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string t, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_sel = 1; reg_write = 1; reg_addr = a; reg_wdata = d;
    step();
    reg_sel = 0; reg_write = 0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string t);
    exp_q.push_back(e); tag_q.push_back(t);
    reg_sel = 1; reg_write = 0; reg_addr = a;
    step();
    reg_sel = 0;
    chk(tag_q.pop_front(), {96'd0, reg_rdata}, {96'd0, exp_q.pop_front()});
  endtask

  task automatic pop_inst(input string t);
    chk(t, inst_rdata, inst_q.pop_front());
    inst_rrequest = 1;
    step();
    inst_rrequest = 0;
  endtask

  initial begin
    logic [127:0] e;
    repeat (3) step();
    chk("rst_rdata", {96'd0, reg_rdata}, 0);
    chk("rst_clear_req", {127'd0, clear_request}, 0);
    chk("rst_config", {127'd0, core_config}, 0);
    chk("rst_inst_rready", {127'd0, inst_rready}, 0);
    rstnn = 1;
    step();
    chk("rst_log_wready", {127'd0, log_wready}, 1);
    rd(5'h00, 0, "rst_CONFIG");
    rd(5'h04, 32'h1234_5678, "rst_STATUS");
    rd(5'h08, 0, "rst_CLEAR");
    rd(5'h0C, 0, "rst_INST_DATA");
    rd(5'h10, 0, "rst_INST_LEVEL");
    rd(5'h14, 0, "rst_LOG_DATA");
    rd(5'h18, 0, "rst_LOG_LEVEL");
    rd(5'h1C, 0, "rst_FINISH_CNT");

    wr(5'h00, 32'h1);
    chk("config_out", {127'd0, core_config}, 1);
    rd(5'h03, 32'h1, "config_rd_lowbits_ignored");

    // Instruction packing
    wr(5'h0C, 32'h11);
    rd(5'h10, 32'h0001_0000, "stage_wcnt1");
    wr(5'h0C, 32'h22);
    wr(5'h0C, 32'h33);
    chk("pack_not_ready", {127'd0, inst_rready}, 0);
    wr(5'h0C, 32'h44);
    inst_q.push_back({32'h44, 32'h33, 32'h22, 32'h11});
    chk("pack_rready", {127'd0, inst_rready}, 1);
    pop_inst("pack_rdata");
    chk("pack_popped", {127'd0, inst_rready}, 0);
    inst_rrequest = 1; step(); inst_rrequest = 0;
    rd(5'h10, 0, "pop_empty_ignored");

    // Overflow: fifth instruction is dropped
    for (int k = 0; k < 5; k++) begin
      for (int w = 0; w < 4; w++) begin
        e[w*32 +: 32] = 32'h100 * k + w;
        wr(5'h0C, 32'h100 * k + w);
      end
      if (k < 4) inst_q.push_back(e);
    end
    rd(5'h10, 32'hC000_0004, "ovf_level");
    wr(5'h10, 32'h0);
    rd(5'h10, 32'h8000_0004, "ovf_cleared");
    pop_inst("ovf_head0");
    pop_inst("ovf_head1");
    wr(5'h0C, 32'hDEAD);
    rd(5'h10, 32'h0001_0002, "pre_clear_level");

    // Clear
    wr(5'h08, 32'h1);
    inst_q.delete();
    chk("clr_request", {127'd0, clear_request}, 1);
    chk("clr_rready", {127'd0, inst_rready}, 0);
    chk("clr_wready", {127'd0, log_wready}, 0);
    rd(5'h10, 0, "clr_level");
    wr(5'h0C, 32'hBEEF);
    rd(5'h10, 0, "clr_inst_ignored");
    rd(5'h08, 1, "clr_busy");
    clear_finish = 1;
    repeat (3) step();
    clear_finish = 0;
    chk("clr_req_dropped", {127'd0, clear_request}, 0);
    rd(5'h08, 0, "clr_done");
    rd(5'h00, 1, "clr_config_kept");
    chk("clr_wready_back", {127'd0, log_wready}, 1);

    // Log round trip with LOG_DEPTH=2
    log_wrequest = 1;
    log_wdata = 32'hA; step();
    log_wdata = 32'hB; step();
    chk("log_full_wready", {127'd0, log_wready}, 0);
    log_wdata = 32'hC; step();
    log_wdata = 32'hD; step();
    log_wrequest = 0;
    rd(5'h18, 32'h8000_0002, "log_level_full");
    rd(5'h14, 32'hA, "log_pop0");
    rd(5'h14, 32'hB, "log_pop1");
    rd(5'h14, 0, "log_empty_read");
    rd(5'h18, 0, "log_level_empty");

    // Finish counter
    repeat (5) begin
      op_finish = 1; step(); op_finish = 0; step();
    end
    rd(5'h1C, 5, "fin_cnt5");
    op_finish = 1;
    wr(5'h1C, 32'h0);
    op_finish = 0;
    rd(5'h1C, 1, "fin_clear_coincide");
    wr(5'h1C, 32'h0);
    rd(5'h1C, 0, "fin_clear");

    // Reset during a clear in progress
    wr(5'h08, 32'h1);
    chk("mid_clear_req", {127'd0, clear_request}, 1);
    rstnn = 0; #1;
    chk("mid_rst_clear_req", {127'd0, clear_request}, 0);
    chk("mid_rst_config", {127'd0, core_config}, 0);
    step();
    rstnn = 1;
    step();
    rd(5'h08, 0, "mid_rst_clear_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dca_matrix_mac_mmiox_control.md
# dca_matrix_mac_mmiox_control

Register-mapped control front end that sits directly upstream of the matrix MAC MMIOX datapath and drives its `control_rmx_*` port group. The host writes instructions in 32-bit words, which are packed and queued into an instruction FIFO; the core drains that FIFO. The block also queues core log entries for the host, runs the clear handshake, exposes configuration and status, and counts operation completions. The input-FIFO and output-FIFO channels are out of scope and are served elsewhere.

## Interface
- `BW_INST`, 128: instruction width; multiple of 32; `INST_WORDS = BW_INST/32`.
- `BW_LOG`, 32: log entry width; ≤ 32.
- `BW_STATUS`, 32: core status width; ≤ 32.
- `INST_DEPTH`, 4: instruction FIFO depth; power of 2, ≥ 2.
- `LOG_DEPTH`, 4: log FIFO depth; power of 2, ≥ 2.

Ports:
- `clk` in 1: clock, single domain.
- `rstnn` in 1: asynchronous active-low reset.
- `reg_sel` in 1: register access strobe, one cycle per access.
- `reg_write` in 1: 1 = write, 0 = read.
- `reg_addr` in 5: byte address; bits [1:0] are ignored.
- `reg_wdata` in 32: write data.
- `reg_rdata` out 32: registered read data.
- `control_rmx_core_config` out 1: CONFIG bit 0.
- `control_rmx_core_status` in BW_STATUS: core status.
- `control_rmx_clear_request` out 1: clear request to the core.
- `control_rmx_clear_finish` in 1: core clear done.
- `control_rmx_log_fifo_wready` out 1: log FIFO not full.
- `control_rmx_log_fifo_wrequest` in 1: core pushes a log entry.
- `control_rmx_log_fifo_wdata` in BW_LOG: log entry.
- `control_rmx_inst_fifo_rready` out 1: instruction FIFO not empty.
- `control_rmx_inst_fifo_rdata` out BW_INST: instruction FIFO head.
- `control_rmx_inst_fifo_rrequest` in 1: core pops an instruction.
- `control_rmx_operation_finish` in 1: one-cycle completion pulse.

## Operation
Register map:
- **0x00 CONFIG (RW):** bit 0 drives `core_config`.
- **0x04 STATUS (RO):** `core_status`, zero-extended to 32 bits.
- **0x08 CLEAR:**
  - Writing with wdata[0]=1 starts a clear.
  - Read returns bit 0 = clear busy.
- **0x0C INST_DATA (WO):**
  - Each write stores a word into staging slot `wcnt`; `wcnt` counts 0..INST_WORDS-1.
  - Word 0 lands in bits [31:0] (little-endian packing).
  - The write that fills the last slot pushes the assembled instruction and returns `wcnt` to 0.
- **0x10 INST_LEVEL (RO):**
  - [15:0] = occupancy.
  - [23:16] = `wcnt`.
  - 30 = sticky overflow.
  - 31 = full.
  - Any write clears overflow.
- **0x14 LOG_DATA (RO, pop on read):**
  - Returns the head entry, zero-extended, and pops it.
  - Reading an empty FIFO returns 0 and pops nothing.
- **0x18 LOG_LEVEL (RO):** [15:0] = occupancy; 31 = full.
- **0x1C FINISH_CNT:**
  - 32-bit count of `operation_finish` pulses; wraps 0xFFFFFFFF → 0.
  - Any write clears it to 0.
  - If a clearing write and a pulse coincide, the count becomes 1.
- Unmapped addresses read 0; writes to them are ignored.

FIFOs:
- **Instruction FIFO:**
  - `rready = (count != 0)`; `rdata` = head entry, with no read latency.
  - `rrequest` while empty is ignored.
- **Log FIFO:**
  - `wready = (count != LOG_DEPTH)`.
  - `wrequest` while full is dropped.
- Push is allowed only if the FIFO is not full at the start of the cycle; a pop in the same cycle does not make room.
- If the completing INST_DATA write finds the FIFO full, the instruction is dropped, overflow is set and `wcnt` still returns to 0.
- A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.

Clear state machine, states IDLE → REQ → IDLE:
- IDLE→REQ on a CLEAR write with wdata[0]=1. In that same edge:
  - Both FIFOs empty.
  - `wcnt` resets to 0.
  - Overflow clears.
- In REQ:
  - `clear_request` = 1.
  - INST_DATA writes are ignored.
  - `inst rready` = 0.
  - `log wready` = 0.
- REQ→IDLE on the edge where `clear_finish` = 1; `clear_request` drops in the next cycle.
- A CLEAR write during REQ is ignored.
- CONFIG and FINISH_CNT are not affected by clear.

## Timing
- Reset values: `reg_rdata` = 0, `clear_request` = 0, `core_config` = 0, `inst rready` = 0, `log wready` = 1; FIFOs, `wcnt`, overflow and FINISH_CNT are all 0.
- Read latency is 1: `reg_rdata` is valid the cycle after a `reg_sel` read and holds until the next read.
- A register write takes effect at the access edge.
- Instruction push latency: the last INST_DATA write at edge N gives `inst rready` = 1 in cycle N+1.
- Log push latency: a log push at edge N is readable by a LOG_DATA read issued in cycle N+1.
- Back-to-back register accesses are allowed every cycle.
- Reset asserted mid-operation returns everything to the reset values immediately, including a clear in progress.

## Test plan
- **Reset defaults:** reset, then read all 8 registers → `core_config` = 0 and LOG_LEVEL = 0; all other outputs at their reset values.
- **Instruction packing:** BW_INST=128; write INST_DATA with 0x11, 0x22, 0x33, 0x44 → one cycle later `rready` = 1 and `rdata` = 0x00000044_00000033_00000022_00000011; core pops → `rready` = 0 next cycle.
- **Instruction overflow:** INST_DEPTH=4, push 5 instructions with no pops → INST_LEVEL = 0xC0000004; a write to INST_LEVEL → 0x80000004.
- **Log round trip:** core pushes 0xA, 0xB, then attempts a third and fourth push (LOG_DEPTH=2) → `wready` = 0 after the second push; LOG_DATA reads return 0xA, 0xB, then 0.
- **Clear:** 2 instructions queued plus 1 word staged, then write CLEAR=1:
  - `clear_request` = 1, FIFO empty, `wcnt` = 0.
  - An INST_DATA write is ignored while busy.
  - Hold `clear_finish` for 3 cycles → CLEAR reads 0 afterwards.
- **Finish counter:** 5 `operation_finish` pulses → FINISH_CNT = 5; a clearing write coinciding with a pulse → 1.
